// File: rtl/solo_squash_reset_sequencer.sv
// Start-up reset sequencer for the solo_squash core: synchronizes the pad reset and GPIO-ready flag,
// holds design_reset until both are stable for a qualification plus hold window. Optional: RSTSEQ_SOFT_RESET_EN.
module solo_squash_reset_sequencer #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned READY_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES  = 8,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             ext_reset_n,
    input  logic             gpio_ready,
`ifdef RSTSEQ_SOFT_RESET_EN
    input  logic             soft_reset_req,
`endif
    output logic             design_reset,
    output logic             gpio_ready_sync,
    output logic [1:0]       seq_state,
    output logic [CNT_W-1:0] reset_count
);

    localparam int unsigned CNT_MAX = (READY_CYCLES > HOLD_CYCLES) ? READY_CYCLES : HOLD_CYCLES;
    localparam int unsigned CTR_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_WAIT_READY = 2'd0,
        ST_HOLD       = 2'd1,
        ST_RUN        = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CTR_W-1:0]   ctr_q, ctr_d;
    logic [CNT_W-1:0]   rcnt_d;
    logic               dr_d;
    logic               run_exit;
    logic [SYNC_STAGES-1:0] ext_sync, rdy_sync;
    logic               qual;
    logic               soft_req;
    logic               abort;

`ifdef RSTSEQ_SOFT_RESET_EN
    assign soft_req = soft_reset_req;
`else
    assign soft_req = 1'b0;
`endif

    // Metastability synchronizers for the two asynchronous inputs
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ext_sync <= '0;
            rdy_sync <= '0;
        end else begin
            ext_sync <= {ext_sync[SYNC_STAGES-2:0], ext_reset_n};
            rdy_sync <= {rdy_sync[SYNC_STAGES-2:0], gpio_ready};
        end
    end

    assign qual            = ext_sync[SYNC_STAGES-1] & rdy_sync[SYNC_STAGES-1];
    assign gpio_ready_sync = rdy_sync[SYNC_STAGES-1];
    // A soft request has the same priority as losing qualification
    assign abort           = ~qual | soft_req;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q      <= ST_WAIT_READY;
            ctr_q        <= '0;
            design_reset <= 1'b1;
            reset_count  <= '0;
        end else begin
            state_q      <= state_d;
            ctr_q        <= ctr_d;
            design_reset <= dr_d;
            reset_count  <= rcnt_d;
        end
    end

    // Next-state and shared counter; abort outranks terminal counts
    always_comb begin
        state_d  = state_q;
        ctr_d    = ctr_q;
        run_exit = 1'b0;
        rcnt_d   = reset_count;
        dr_d     = 1'b1;
        case (state_q)
            ST_WAIT_READY: begin
                if (abort) begin
                    ctr_d = '0;
                end else if (ctr_q == CTR_W'(READY_CYCLES - 1)) begin
                    state_d = ST_HOLD;
                    ctr_d   = '0;
                end else begin
                    ctr_d = ctr_q + CTR_W'(1);
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_d = ST_WAIT_READY;
                    ctr_d   = '0;
                end else if (ctr_q == CTR_W'(HOLD_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    ctr_d   = '0;
                end else begin
                    ctr_d = ctr_q + CTR_W'(1);
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d  = ST_WAIT_READY;
                    ctr_d    = '0;
                    run_exit = 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT_READY;
                ctr_d   = '0;
            end
        endcase
        if (run_exit && (reset_count != {CNT_W{1'b1}})) begin
            rcnt_d = reset_count + CNT_W'(1);
        end
        dr_d = (state_d != ST_RUN);
    end

    assign seq_state = state_q;

endmodule
